// File: rtl/parity_checker_rx.sv
// rtl/parity_checker_rx.sv - serial frame receiver with parity check and one-deep output register
// Optional error counter: define PARITY_CHECKER_ERRCNT_EN to add err_count.
module parity_checker_rx #(
  parameter int DATA_W = 3,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef PARITY_CHECKER_ERRCNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              overflow
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              run_par;
  logic              frame_done;
  logic              err_next;

  assign frame_done = (state == PAR) && bit_valid;
  assign err_next   = run_par ^ bit_in ^ ODD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      run_par    <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
`ifdef PARITY_CHECKER_ERRCNT_EN
      err_count  <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: if (bit_valid) begin
          shreg   <= {{(DATA_W-1){1'b0}}, bit_in};
          run_par <= bit_in;
          cnt     <= ONE;
          busy    <= 1'b1;
          state   <= DATA;
        end
        DATA: if (bit_valid) begin
          shreg   <= {shreg[DATA_W-2:0], bit_in};
          run_par <= run_par ^ bit_in;
          cnt     <= cnt + ONE;
          if (cnt + ONE == LAST) state <= PAR;
        end
        PAR: if (bit_valid) begin
          cnt     <= '0;
          run_par <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A completed frame only lands if the register is empty or draining this edge.
      if (frame_done) begin
        if (!out_valid || out_ready) begin
          data_out   <= shreg;
          parity_err <= err_next;
          out_valid  <= 1'b1;
        end else begin
          overflow   <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

`ifdef PARITY_CHECKER_ERRCNT_EN
      if (frame_done && err_next && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_parity_checker_rx.sv
// tb/tb_parity_checker_rx.sv - self-checking bench for parity_checker_rx (even and odd instances)
module tb_parity_checker_rx;

  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic out_ready = 1'b0;

  logic [DW-1:0] d0, d1;
  logic e0, e1, v0, v1, b0, b1, o0, o1;
`ifdef PARITY_CHECKER_ERRCNT_EN
  logic [7:0] c0, c1;
`endif

  parity_checker_rx #(.DATA_W(DW), .ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(d0), .parity_err(e0), .out_valid(v0), .out_ready(out_ready),
    .busy(b0),
`ifdef PARITY_CHECKER_ERRCNT_EN
    .err_count(c0),
`endif
    .overflow(o0)
  );

  parity_checker_rx #(.DATA_W(DW), .ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(d1), .parity_err(e1), .out_valid(v1), .out_ready(out_ready),
    .busy(b1),
`ifdef PARITY_CHECKER_ERRCNT_EN
    .err_count(c1),
`endif
    .overflow(o1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the frame in flight plus the output register contents.
  int            q[$];
  logic          m_valid, m_err0, m_err1, m_ovf, m_busy;
  logic [DW-1:0] m_data;
  int            m_cnt0, m_cnt1;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    int            gap;
    logic [DW-1:0] exp_data;
    logic          exp_e0;
    logic          exp_e1;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0; m_err0 = 1'b0; m_err1 = 1'b0;
    m_ovf = 1'b0; m_busy = 1'b0; m_data = '0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic compare_all();
    check("even.data_out", 32'(d0), 32'(m_data));
    check("odd.data_out", 32'(d1), 32'(m_data));
    check("even.parity_err", 32'(e0), 32'(m_err0));
    check("odd.parity_err", 32'(e1), 32'(m_err1));
    check("even.out_valid", 32'(v0), 32'(m_valid));
    check("odd.out_valid", 32'(v1), 32'(m_valid));
    check("even.busy", 32'(b0), 32'(m_busy));
    check("odd.busy", 32'(b1), 32'(m_busy));
    check("even.overflow", 32'(o0), 32'(m_ovf));
    check("odd.overflow", 32'(o1), 32'(m_ovf));
`ifdef PARITY_CHECKER_ERRCNT_EN
    check("even.err_count", 32'(c0), 32'(m_cnt0));
    check("odd.err_count", 32'(c1), 32'(m_cnt1));
`endif
  endtask

  task automatic step(input logic v, input logic b, input logic r);
    int            ones;
    int            word;
    logic          done, consume, bad_even, bad_odd;
    @(negedge clk);
    bit_valid = v; bit_in = b; out_ready = r;
    consume = m_valid && r;
    done = 1'b0; bad_even = 1'b0; bad_odd = 1'b0; word = 0;
    if (v) begin
      q.push_back(int'(b));
      if (q.size() == DW + 1) begin
        done = 1'b1;
        ones = 0;
        for (int i = 0; i <= DW; i++) ones += q[i];
        for (int i = 0; i < DW; i++) word += q[i] * (2 ** (DW - 1 - i));
        bad_even = (ones % 2) != 0;
        bad_odd  = (ones % 2) != 1;
        q.delete();
        if (bad_even && m_cnt0 < 255) m_cnt0++;
        if (bad_odd && m_cnt1 < 255) m_cnt1++;
      end
    end
    if (done && (!m_valid || r)) begin
      m_data = DW'(word); m_err0 = bad_even; m_err1 = bad_odd; m_valid = 1'b1;
    end else if (done) begin
      m_ovf = 1'b1;
    end else if (consume) begin
      m_valid = 1'b0;
    end
    m_busy = q.size() > 0;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input int gap,
                            input logic rd, input logic rp);
    for (int i = 0; i < DW; i++) begin
      step(1'b1, d[DW-1-i], rd);
      repeat (gap) step(1'b0, 1'($urandom), rd);
    end
    step(1'b1, p, rp);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    bit_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst.busy_async", 32'(b0), 32'd0);
    check("rst.valid_async", 32'(v0), 32'd0);
    check("rst.overflow_async", 32'(o0), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tbl[i].data = DW'(i);
      tbl[i].gap = 0;
      tbl[i].exp_data = DW'(i);
      tbl[i].exp_e0 = 1'b0;
      tbl[i].exp_e1 = 1'b1;
    end
    tbl[0].par = 1'b0; tbl[1].par = 1'b1; tbl[2].par = 1'b1; tbl[3].par = 1'b0;
    tbl[4].par = 1'b1; tbl[5].par = 1'b0; tbl[6].par = 1'b0; tbl[7].par = 1'b1;
    tbl[8] = '{data: 3'b101, par: 1'b1, gap: 0, exp_data: 3'b101, exp_e0: 1'b1, exp_e1: 1'b0};
    tbl[9] = '{data: 3'b110, par: 1'b0, gap: 3, exp_data: 3'b110, exp_e0: 1'b0, exp_e1: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].data, tbl[i].par, tbl[i].gap, 1'b1, 1'b1);
      check("tbl.out_valid", 32'(v0), 32'd1);
      check("tbl.data_out", 32'(d0), 32'(tbl[i].exp_data));
      check("tbl.err_even", 32'(e0), 32'(tbl[i].exp_e0));
      check("tbl.err_odd", 32'(e1), 32'(tbl[i].exp_e1));
    end
    step(1'b0, 1'b0, 1'b1);

    send_frame(3'b011, 1'b0, 0, 1'b0, 1'b0);
    send_frame(3'b100, 1'b1, 0, 1'b0, 1'b0);
    check("ovf.data_held", 32'(d0), 32'b011);
    check("ovf.sticky", 32'(o0), 32'd1);
    check("ovf.valid", 32'(v0), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("ovf.still_set", 32'(o0), 32'd1);

    do_reset();
    send_frame(3'b011, 1'b0, 0, 1'b0, 1'b0);
    send_frame(3'b100, 1'b1, 0, 1'b0, 1'b1);
    check("drain.data_out", 32'(d0), 32'b100);
    check("drain.overflow", 32'(o0), 32'd0);
    check("drain.err_even", 32'(e0), 32'd0);
    step(1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("mid.busy", 32'(b0), 32'd1);
    do_reset();
    send_frame(3'b111, 1'b1, 0, 1'b1, 1'b1);
    check("mid.data_out", 32'(d0), 32'b111);
    check("mid.err_even", 32'(e0), 32'd0);
    check("mid.busy_after", 32'(b0), 32'd0);

    repeat (3000)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 9) < 6));

`ifdef PARITY_CHECKER_ERRCNT_EN
    do_reset();
    repeat (260) send_frame(3'b101, 1'b1, 0, 1'b1, 1'b1);
    check("cnt.saturate", 32'(c0), 32'd255);
    check("cnt.good_frames", 32'(c1), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
